// File: rtl/mult_pkg.sv
// Shared ALU codes, width helpers and the stage record type for the pipelined multiplier.
// The ALU codes mirror the encodings of the EX-stage decoder.
package mult_pkg;

    localparam logic [4:0] ALU_MUL    = 5'h0A;
    localparam logic [4:0] ALU_MULH   = 5'h0B;
    localparam logic [4:0] ALU_MULHSU = 5'h0C;
    localparam logic [4:0] ALU_MULHU  = 5'h0D;
    localparam logic [4:0] ALU_FMULS  = 5'h0E;

    function automatic int ext_w(input int xlen);
        return xlen + 1;
    endfunction

    function automatic int prod_w(input int xlen);
        return 2 * xlen + 2;
    endfunction

    // ceil((xlen+1)/stages): bits of ext_b consumed by each stage
    function automatic int chunk_w(input int xlen, input int stages);
        return (xlen + stages) / stages;
    endfunction

    localparam int DEF_XLEN   = 32;
    localparam int DEF_STAGES = 4;
    localparam int DEF_TAG_W  = 5;
    localparam int DEF_EXT_W  = ext_w(DEF_XLEN);
    localparam int DEF_PROD_W = prod_w(DEF_XLEN);
    localparam int DEF_PAD_W  = chunk_w(DEF_XLEN, DEF_STAGES) * DEF_STAGES;

    typedef struct packed {
        logic                  valid;
        logic [DEF_PROD_W-1:0] acc;
        logic [DEF_EXT_W-1:0]  ext_a;
        logic [DEF_PAD_W-1:0]  ext_b_rem;
        logic [DEF_TAG_W-1:0]  tag;
        logic [4:0]            func;
    } mult_stage_t;

endpackage

// File: rtl/mult_stage.sv
// One pipeline register of the multiplier: accumulates ext_a times the low chunk of the
// remaining ext_b bits, then shifts that chunk out for the next stage.
module mult_stage
    import mult_pkg::*;
#(
    parameter int EXT_W   = 33,
    parameter int PROD_W  = 66,
    parameter int PAD_W   = 36,
    parameter int CHUNK_W = 9,
    parameter int TAG_W   = 5,
    parameter int SHIFT   = 0,
    parameter bit LAST    = 1'b0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              hold,
    input  logic              in_valid,
    input  logic [PROD_W-1:0] in_acc,
    input  logic [EXT_W-1:0]  in_a,
    input  logic [PAD_W-1:0]  in_b_rem,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic [4:0]        in_func,
    output logic              out_valid,
    output logic [PROD_W-1:0] out_acc,
    output logic [EXT_W-1:0]  out_a,
    output logic [PAD_W-1:0]  out_b_rem,
    output logic [TAG_W-1:0]  out_tag,
    output logic [4:0]        out_func
);

    logic              valid_d, valid_q;
    logic [PROD_W-1:0] acc_d, acc_q;
    logic [EXT_W-1:0]  a_d, a_q;
    logic [PAD_W-1:0]  b_rem_d, b_rem_q;
    logic [TAG_W-1:0]  tag_d, tag_q;
    logic [4:0]        func_d, func_q;

    logic [PROD_W-1:0] a_wide, chunk_wide, partial;
    logic [PAD_W-1:0]  b_shifted;

    // Only the most significant chunk carries the sign of ext_b
    always_comb begin
        a_wide     = {{(PROD_W-EXT_W){in_a[EXT_W-1]}}, in_a};
        chunk_wide = {{(PROD_W-CHUNK_W){LAST & in_b_rem[CHUNK_W-1]}}, in_b_rem[CHUNK_W-1:0]};
        partial    = (a_wide * chunk_wide) << SHIFT;
        b_shifted  = $signed(in_b_rem) >>> CHUNK_W;
    end

    always_comb begin
        valid_d = valid_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_rem_d = b_rem_q;
        tag_d   = tag_q;
        func_d  = func_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (!hold) begin
            valid_d = in_valid;
            acc_d   = in_acc + partial;
            a_d     = in_a;
            b_rem_d = b_shifted;
            tag_d   = in_tag;
            func_d  = in_func;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            acc_q   <= '0;
            a_q     <= '0;
            b_rem_q <= '0;
            tag_q   <= '0;
            func_q  <= '0;
        end else begin
            valid_q <= valid_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_rem_q <= b_rem_d;
            tag_q   <= tag_d;
            func_q  <= func_d;
        end
    end

    assign out_valid = valid_q;
    assign out_acc   = acc_q;
    assign out_a     = a_q;
    assign out_b_rem = b_rem_q;
    assign out_tag   = tag_q;
    assign out_func  = func_q;

endmodule

// File: rtl/pipelined_multiplier.sv
// STAGES-deep shift-add multiplier for MUL/MULH/MULHSU/MULHU and FMULS mantissas,
// with valid/ready handshake, whole-pipe stall on backpressure and synchronous flush.
module pipelined_multiplier
    import mult_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 4,
    parameter int TAG_W  = 5,
    parameter int MAN_W  = 23
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     opa,
    input  logic [XLEN-1:0]     opb,
    input  logic [4:0]          alu_func,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*XLEN+1:0]   mult_res,
    output logic [TAG_W-1:0]    out_tag,
    output logic [4:0]          out_func,
    output logic                busy
);

    localparam int EXT_W   = ext_w(XLEN);
    localparam int PROD_W  = prod_w(XLEN);
    localparam int CHUNK_W = chunk_w(XLEN, STAGES);
    localparam int PAD_W   = CHUNK_W * STAGES;

    logic [MAN_W:0]   fp_a, fp_b;
    logic [EXT_W-1:0] ext_a, ext_b;
    logic [PAD_W-1:0] ext_b_pad;
    logic             stall;

    logic [STAGES:0]   v_pipe;
    logic [PROD_W-1:0] acc_pipe  [STAGES+1];
    logic [EXT_W-1:0]  a_pipe    [STAGES+1];
    logic [PAD_W-1:0]  b_pipe    [STAGES+1];
    logic [TAG_W-1:0]  tag_pipe  [STAGES+1];
    logic [4:0]        func_pipe [STAGES+1];

    // Mantissa with hidden bit restored unless the exponent is zero (denormal)
    always_comb begin
        fp_a = {|opa[MAN_W+7:MAN_W], opa[MAN_W-1:0]};
        fp_b = {|opb[MAN_W+7:MAN_W], opb[MAN_W-1:0]};
        case (alu_func)
            ALU_FMULS: begin
                ext_a = EXT_W'(fp_a);
                ext_b = EXT_W'(fp_b);
            end
            ALU_MULH: begin
                ext_a = {opa[XLEN-1], opa};
                ext_b = {opb[XLEN-1], opb};
            end
            ALU_MULHSU: begin
                ext_a = {opa[XLEN-1], opa};
                ext_b = {1'b0, opb};
            end
            default: begin
                ext_a = {1'b0, opa};
                ext_b = {1'b0, opb};
            end
        endcase
        ext_b_pad = PAD_W'($signed(ext_b));
    end

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    assign v_pipe[0]    = in_valid && in_ready;
    assign acc_pipe[0]  = '0;
    assign a_pipe[0]    = ext_a;
    assign b_pipe[0]    = ext_b_pad;
    assign tag_pipe[0]  = in_tag;
    assign func_pipe[0] = alu_func;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        mult_stage #(
            .EXT_W   (EXT_W),
            .PROD_W  (PROD_W),
            .PAD_W   (PAD_W),
            .CHUNK_W (CHUNK_W),
            .TAG_W   (TAG_W),
            .SHIFT   (i * CHUNK_W),
            .LAST    (i == STAGES - 1)
        ) u_stage (
            .clock     (clock),
            .reset_n   (reset_n),
            .flush     (flush),
            .hold      (stall),
            .in_valid  (v_pipe[i]),
            .in_acc    (acc_pipe[i]),
            .in_a      (a_pipe[i]),
            .in_b_rem  (b_pipe[i]),
            .in_tag    (tag_pipe[i]),
            .in_func   (func_pipe[i]),
            .out_valid (v_pipe[i+1]),
            .out_acc   (acc_pipe[i+1]),
            .out_a     (a_pipe[i+1]),
            .out_b_rem (b_pipe[i+1]),
            .out_tag   (tag_pipe[i+1]),
            .out_func  (func_pipe[i+1])
        );
    end

    // Operands leaving the final stage have no consumer
    logic unused_ops;
    assign unused_ops = ^{a_pipe[STAGES], b_pipe[STAGES]};

    assign out_valid = v_pipe[STAGES];
    assign mult_res  = acc_pipe[STAGES];
    assign out_tag   = tag_pipe[STAGES];
    assign out_func  = func_pipe[STAGES];
    assign busy      = |v_pipe[STAGES:1];

endmodule
